fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the fetch stage: owns the PC register and issues reads to a variable-latency instruction memory.
- Holds each returned instruction for decode under a valid/stall handshake.
- Applies branch redirects, with a flush of any in-flight read.
- Stops fetching and raises a one-cycle dump request when a HALT instruction is consumed.
- Sits between the instruction memory and the decode stage and replaces the free-running PC-plus-2 fetch loop.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, value driven on instr_out whenever no valid instruction is held.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous active-high reset.
- mem_addr  out  16  instruction memory address; equals current PC.
- mem_rd  out  1  one-cycle read request.
- mem_data  in  16  read data; sampled only when mem_done=1.
- mem_done  in  1  read complete; arrives at least 1 cycle after mem_rd.
- stall_in  in  1  decode cannot accept; holds the current instruction.
- branch_taken  in  1  one-cycle redirect pulse.
- branch_target  in  16  redirect PC; sampled when branch_taken=1.
- instr_out  out  16  instruction to decode.
- instr_valid  out  1  instr_out is valid.
- pc_plus2  out  16  (PC of instr_out)+2 while valid, else PC+2.
- halted  out  1  sticky; high in HALTED.
- dump  out  1  one-cycle pulse on entering HALTED.

Behaviour:
- Reset is asynchronous. While rst=1, or immediately after:
  - state=FETCH, pc=RESET_PC.
  - instr_out=NOP_INSTR, instr_valid=0, mem_rd=0.
  - halted=0, dump=0.
- mem_addr=pc at all times. pc_plus2 is combinational pc_of_instr+2.
- All PC arithmetic is 16-bit modulo: 16'hFFFE+2 gives 16'h0000, with no flag.
- States:
  - FETCH: mem_rd=1. Next state is WAIT.
  - WAIT: mem_rd=0.
    - On mem_done: instr_out<=mem_data, instr_valid<=1, latch pc_of_instr<=pc, pc<=pc+2, next state VALID.
    - Otherwise remain in WAIT.
  - VALID: instr_valid=1.
    - If stall_in=1: hold instr_out, pc and state.
    - If stall_in=0, the instruction is consumed that cycle:
      - If instr_out[15:11]==5'b00000 (HALT): go to HALTED, dump=1 for that transition cycle only, instr_valid<=0.
      - Otherwise: mem_rd=1 in the same cycle (back-to-back issue), go to WAIT, instr_valid<=0.
  - DRAIN: mem_rd=0. Discards one outstanding response. On mem_done, go to FETCH, ignoring mem_data.
  - HALTED: mem_rd=0, instr_valid=0, halted=1. Only rst exits this state.
- Throughput with a 1-cycle memory and no stall: one instruction every 2 cycles. The first instr_valid appears 2 cycles after reset release.
- Priority: rst > branch_taken > HALT consumption > normal flow.
- Redirect (branch_taken=1 in any state except HALTED):
  - pc<=branch_target, instr_valid<=0, instr_out<=NOP_INSTR.
  - If the state is WAIT and mem_done=0 in that cycle, go to DRAIN. Otherwise go to FETCH.
  - A redirect in the same cycle as mem_done drops that data.
  - A redirect in VALID overrides both stall_in and HALT.
- branch_taken in HALTED is ignored.
- mem_done outside WAIT/DRAIN is ignored.
- branch_target[0] is forced to 0 before loading the PC.
- stall_in is ignored in every state except VALID.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined:
  - Adds output port align_err (1 bit, reset 0, sticky).
  - An odd branch_target on a redirect sets align_err=1 and sends the block to HALTED with dump=1 for one cycle, instead of redirecting.
- When undefined:
  - The port is absent.
  - Odd targets are silently aligned, as described under Redirect.

Test Plan:
- Reset release, memory returns 16'h4001 one cycle after each mem_rd, stall_in=0: mem_rd at cycles 0, 2, 4 with addresses 0, 2, 4; instr_valid at cycles 2, 4; pc_plus2=2 then 4.
- stall_in=1 for 3 cycles while VALID on the instruction at PC 0x0010: instr_out is stable, no mem_rd is issued, mem_addr=0x0012; fetch of 0x0012 starts the cycle stall_in drops.
- branch_taken with target 0x0100 while WAIT, 3-cycle memory: enters DRAIN, stale data is never valid; next mem_rd has address 0x0100; instr_valid shows the data from 0x0100.
- branch_taken together with mem_done in WAIT, target 0x0081: data is dropped; next fetch address is 0x0080 (macro off); with FETCH_ALIGN_CHECK_EN, align_err=1, dump pulses, state is HALTED.
- Consume 16'h0000 at PC 0x0006: dump=1 for exactly one cycle, halted stays 1, no further mem_rd; a later branch_taken is ignored; rst clears everything.
- PC at 0xFFFE consumed: next mem_addr is 0x0000.
- Assert rst mid-WAIT: outputs take reset values immediately; a later mem_done is ignored.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory and decode-side signals of the fetch sequencer
interface fetch_sequencer_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic        mem_done;
    logic        stall_in;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [15:0] pc_plus2;
    logic        halted;
    logic        dump;

    modport master (
        output mem_addr, mem_rd, instr_out, instr_valid, pc_plus2, halted, dump,
        input  mem_data, mem_done, stall_in, branch_taken, branch_target
    );

    modport slave (
        input  mem_addr, mem_rd, instr_out, instr_valid, pc_plus2, halted, dump,
        output mem_data, mem_done, stall_in, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch stage PC owner with redirect/drain and HALT dump request
// Optional FETCH_ALIGN_CHECK_EN: odd redirect targets raise sticky align_err and halt.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic clk,
    input  logic rst,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic align_err,
`endif
    fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_FETCH, S_WAIT, S_VALID, S_DRAIN, S_HALTED} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pc_instr;
    logic [15:0] instr_q;
    logic        valid_q;
    logic        halted_q;
    logic        dump_q;

    logic        redirect;
    logic        align_fault;
    logic        consume;
    logic        is_halt;
    logic [15:0] target;

    assign redirect = bus.branch_taken && (state != S_HALTED);
    assign target   = bus.branch_target & 16'hFFFE;
    assign consume  = (state == S_VALID) && !bus.stall_in && !redirect;
    assign is_halt  = (instr_q[15:11] == 5'b00000);

`ifdef FETCH_ALIGN_CHECK_EN
    assign align_fault = redirect && bus.branch_target[0];
`else
    assign align_fault = 1'b0;
`endif

    // A redirect cycle never issues a read, so no orphan response can be mistaken for new data.
    assign bus.mem_rd      = !rst && !redirect &&
                             ((state == S_FETCH) || (consume && !is_halt));
    assign bus.mem_addr    = pc;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc_plus2    = (valid_q ? pc_instr : pc) + 16'd2;
    assign bus.halted      = halted_q;
    assign bus.dump        = dump_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            pc_instr <= RESET_PC;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            dump_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            align_err <= 1'b0;
`endif
        end else begin
            dump_q <= 1'b0;
            if (align_fault) begin
                state    <= S_HALTED;
                halted_q <= 1'b1;
                dump_q   <= 1'b1;
                valid_q  <= 1'b0;
                instr_q  <= NOP_INSTR;
`ifdef FETCH_ALIGN_CHECK_EN
                align_err <= 1'b1;
`endif
            end else if (redirect) begin
                pc      <= target;
                valid_q <= 1'b0;
                instr_q <= NOP_INSTR;
                // A read still outstanding must be swallowed before the new fetch.
                if (((state == S_WAIT) || (state == S_DRAIN)) && !bus.mem_done)
                    state <= S_DRAIN;
                else
                    state <= S_FETCH;
            end else begin
                case (state)
                    S_FETCH: state <= S_WAIT;
                    S_WAIT: begin
                        if (bus.mem_done) begin
                            instr_q  <= bus.mem_data;
                            valid_q  <= 1'b1;
                            pc_instr <= pc;
                            pc       <= pc + 16'd2;
                            state    <= S_VALID;
                        end
                    end
                    S_VALID: begin
                        if (!bus.stall_in) begin
                            valid_q <= 1'b0;
                            instr_q <= NOP_INSTR;
                            if (is_halt) begin
                                state    <= S_HALTED;
                                halted_q <= 1'b1;
                                dump_q   <= 1'b1;
                            end else begin
                                state <= S_WAIT;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (bus.mem_done)
                            state <= S_FETCH;
                    end
                    S_HALTED: state <= S_HALTED;
                    default:  state <= S_FETCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fetch_sequencer_if bus();
`ifdef FETCH_ALIGN_CHECK_EN
    logic align_err;
`endif

    fetch_sequencer #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .clk(clk),
        .rst(rst),
`ifdef FETCH_ALIGN_CHECK_EN
        .align_err(align_err),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.mem_data = 16'h0000; bus.mem_done = 1'b0; bus.stall_in = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_target = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // From FETCH: redirect to target, fetch it with a 1-cycle memory, end in VALID.
    task automatic to_valid(input logic [15:0] tgt, input logic [15:0] data);
        bus.branch_taken = 1'b1; bus.branch_target = tgt;
        tick;
        bus.branch_taken = 1'b0;
        tick;
        bus.mem_done = 1'b1; bus.mem_data = data;
        tick;
        bus.mem_done = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.mem_data = 16'h0000; bus.mem_done = 1'b0; bus.stall_in = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_target = 16'h0000;
        #1;
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b want 0", bus.mem_rd); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
        checks++; if (bus.instr_out !== 16'h0800) begin errors++; $display("FAIL reset_instr: got %h want 0800", bus.instr_out); end
        checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", bus.mem_addr); end
        checks++; if (bus.halted !== 1'b0 || bus.dump !== 1'b0) begin errors++; $display("FAIL reset_halt_dump: got %b%b want 00", bus.halted, bus.dump); end
        checks++; if (bus.pc_plus2 !== 16'h0002) begin errors++; $display("FAIL reset_pc_plus2: got %h want 0002", bus.pc_plus2); end
`ifdef FETCH_ALIGN_CHECK_EN
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align_err: got %b want 0", align_err); end
`endif
    endtask

    task automatic test_stream;
        do_reset;
        for (int i = 0; i < 3; i++) begin
            settle;
            checks++; if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL stream_rd_%0d: got %b want 1", i, bus.mem_rd); end
            checks++; if (bus.mem_addr !== 16'(2 * i)) begin errors++; $display("FAIL stream_addr_%0d: got %h want %h", i, bus.mem_addr, 16'(2 * i)); end
            checks++; if (bus.instr_valid !== (i > 0)) begin errors++; $display("FAIL stream_valid_%0d: got %b want %b", i, bus.instr_valid, (i > 0)); end
            checks++; if (bus.pc_plus2 !== ((i == 0) ? 16'h0002 : 16'(2 * i))) begin errors++; $display("FAIL stream_pc_plus2_%0d: got %h", i, bus.pc_plus2); end
            if (i > 0) begin
                checks++; if (bus.instr_out !== 16'h4001) begin errors++; $display("FAIL stream_instr_%0d: got %h want 4001", i, bus.instr_out); end
            end
            tick;
            bus.mem_done = 1'b1; bus.mem_data = 16'h4001;
            settle;
            checks++; if (bus.mem_rd !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_wait_%0d: got rd %b valid %b want 0 0", i, bus.mem_rd, bus.instr_valid); end
            tick;
            bus.mem_done = 1'b0;
        end
    endtask

    task automatic test_stall;
        do_reset;
        to_valid(16'h0010, 16'h1234);
        bus.stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle;
            checks++; if (bus.instr_out !== 16'h1234 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_%0d: got %h/%b want 1234/1", k, bus.instr_out, bus.instr_valid); end
            checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL stall_no_rd_%0d: got %b want 0", k, bus.mem_rd); end
            checks++; if (bus.mem_addr !== 16'h0012) begin errors++; $display("FAIL stall_addr_%0d: got %h want 0012", k, bus.mem_addr); end
            tick;
        end
        bus.stall_in = 1'b0;
        settle;
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0012) begin errors++; $display("FAIL stall_release: got rd %b addr %h want 1 0012", bus.mem_rd, bus.mem_addr); end
        tick;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stall_consumed: got %b want 0", bus.instr_valid); end
    endtask

    task automatic test_redirect_wait;
        do_reset;
        to_valid(16'h0040, 16'h4001);
        tick;
        bus.branch_taken = 1'b1; bus.branch_target = 16'h0100;
        tick;
        bus.branch_taken = 1'b0;
        settle;
        checks++; if (bus.instr_valid !== 1'b0 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 16'h0100) begin errors++; $display("FAIL drain_enter: got valid %b rd %b addr %h want 0 0 0100", bus.instr_valid, bus.mem_rd, bus.mem_addr); end
        tick;
        bus.mem_done = 1'b1; bus.mem_data = 16'hDEAD;
        tick;
        bus.mem_done = 1'b0;
        settle;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL drain_stale: got valid %b want 0", bus.instr_valid); end
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0100) begin errors++; $display("FAIL drain_refetch: got rd %b addr %h want 1 0100", bus.mem_rd, bus.mem_addr); end
        tick;
        tick;
        tick;
        bus.mem_done = 1'b1; bus.mem_data = 16'h5555;
        tick;
        bus.mem_done = 1'b0;
        settle;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'h5555) begin errors++; $display("FAIL drain_new_data: got %b/%h want 1/5555", bus.instr_valid, bus.instr_out); end
        checks++; if (bus.pc_plus2 !== 16'h0102) begin errors++; $display("FAIL drain_pc_plus2: got %h want 0102", bus.pc_plus2); end
    endtask

    task automatic test_redirect_with_done;
        do_reset;
        to_valid(16'h0100, 16'h4001);
        tick;
        bus.mem_done = 1'b1; bus.mem_data = 16'h7777;
        bus.branch_taken = 1'b1; bus.branch_target = 16'h0081;
        tick;
        bus.mem_done = 1'b0; bus.branch_taken = 1'b0;
        settle;
`ifdef FETCH_ALIGN_CHECK_EN
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL odd_align_err: got %b want 1", align_err); end
        checks++; if (bus.halted !== 1'b1 || bus.dump !== 1'b1) begin errors++; $display("FAIL odd_halt_dump: got %b%b want 11", bus.halted, bus.dump); end
        checks++; if (bus.instr_valid !== 1'b0 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 16'h0102) begin errors++; $display("FAIL odd_state: got valid %b rd %b addr %h want 0 0 0102", bus.instr_valid, bus.mem_rd, bus.mem_addr); end
        tick;
        checks++; if (bus.dump !== 1'b0 || bus.halted !== 1'b1 || align_err !== 1'b1) begin errors++; $display("FAIL odd_after: got dump %b halted %b align %b want 0 1 1", bus.dump, bus.halted, align_err); end
`else
        checks++; if (bus.instr_valid !== 1'b0 || bus.instr_out !== 16'h0800) begin errors++; $display("FAIL done_drop: got %b/%h want 0/0800", bus.instr_valid, bus.instr_out); end
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0080) begin errors++; $display("FAIL done_refetch: got rd %b addr %h want 1 0080", bus.mem_rd, bus.mem_addr); end
        tick;
        bus.mem_done = 1'b1; bus.mem_data = 16'h4001;
        tick;
        bus.mem_done = 1'b0;
        settle;
        checks++; if (bus.instr_valid !== 1'b1 || bus.pc_plus2 !== 16'h0082) begin errors++; $display("FAIL done_next: got valid %b pc_plus2 %h want 1 0082", bus.instr_valid, bus.pc_plus2); end
`endif
    endtask

    task automatic test_pc_wrap;
        do_reset;
        to_valid(16'hFFFE, 16'h4001);
        settle;
        checks++; if (bus.pc_plus2 !== 16'h0000) begin errors++; $display("FAIL wrap_pc_plus2: got %h want 0000", bus.pc_plus2); end
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr: got rd %b addr %h want 1 0000", bus.mem_rd, bus.mem_addr); end
    endtask

    task automatic test_halt;
        do_reset;
        to_valid(16'h0006, 16'h0000);
        settle;
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL halt_no_issue: got %b want 0", bus.mem_rd); end
        tick;
        checks++; if (bus.dump !== 1'b1 || bus.halted !== 1'b1) begin errors++; $display("FAIL halt_enter: got dump %b halted %b want 1 1", bus.dump, bus.halted); end
        checks++; if (bus.instr_valid !== 1'b0 || bus.mem_rd !== 1'b0) begin errors++; $display("FAIL halt_idle: got valid %b rd %b want 0 0", bus.instr_valid, bus.mem_rd); end
        tick;
        checks++; if (bus.dump !== 1'b0 || bus.halted !== 1'b1) begin errors++; $display("FAIL halt_pulse: got dump %b halted %b want 0 1", bus.dump, bus.halted); end
        bus.branch_taken = 1'b1; bus.branch_target = 16'h0200; bus.mem_done = 1'b1;
        settle;
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL halt_branch_rd: got %b want 0", bus.mem_rd); end
        tick;
        bus.branch_taken = 1'b0; bus.mem_done = 1'b0;
        checks++; if (bus.mem_addr !== 16'h0008 || bus.halted !== 1'b1 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL halt_branch_ignored: got addr %h halted %b valid %b want 0008 1 0", bus.mem_addr, bus.halted, bus.instr_valid); end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (bus.mem_rd !== 1'b0 || bus.dump !== 1'b0) begin errors++; $display("FAIL halt_quiet_%0d: got rd %b dump %b want 0 0", k, bus.mem_rd, bus.dump); end
        end
        rst = 1'b1;
        #1;
        checks++; if (bus.halted !== 1'b0 || bus.mem_addr !== 16'h0000 || bus.mem_rd !== 1'b0) begin errors++; $display("FAIL halt_rst: got halted %b addr %h rd %b want 0 0000 0", bus.halted, bus.mem_addr, bus.mem_rd); end
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        do_reset;
        to_valid(16'h0030, 16'h4001);
        tick;
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_addr !== 16'h0000 || bus.instr_valid !== 1'b0 || bus.instr_out !== 16'h0800 || bus.mem_rd !== 1'b0) begin errors++; $display("FAIL midwait_rst: got addr %h valid %b instr %h rd %b want 0000 0 0800 0", bus.mem_addr, bus.instr_valid, bus.instr_out, bus.mem_rd); end
        tick;
        bus.mem_done = 1'b1; bus.mem_data = 16'h4444;
        tick;
        rst = 1'b0;
        settle;
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL midwait_fetch: got rd %b addr %h want 1 0000", bus.mem_rd, bus.mem_addr); end
        tick;
        bus.mem_done = 1'b0;
        settle;
        checks++; if (bus.instr_valid !== 1'b0 || bus.mem_rd !== 1'b0) begin errors++; $display("FAIL midwait_ignored: got valid %b rd %b want 0 0", bus.instr_valid, bus.mem_rd); end
        bus.mem_done = 1'b1; bus.mem_data = 16'h6666;
        tick;
        bus.mem_done = 1'b0;
        settle;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'h6666 || bus.pc_plus2 !== 16'h0002) begin errors++; $display("FAIL midwait_data: got %b/%h/%h want 1/6666/0002", bus.instr_valid, bus.instr_out, bus.pc_plus2); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_stall;
        test_redirect_wait;
        test_redirect_with_done;
        test_pc_wrap;
        test_halt;
        test_reset_mid_wait;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
